// File: rtl/cy_skid_fifo_if.sv
// Handshake bundle between an upstream producer, the skid FIFO and a
// downstream consumer. The FIFO sits on the slave side of this bundle.
interface cy_skid_fifo_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic [AW:0]   o_count;

    // Environment side: produces upstream words, consumes output words.
    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_count
    );

    // FIFO side.
    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_count
    );
endinterface

// File: rtl/cy_skid_fifo.sv
// Small show-ahead FIFO with registered o_ready, o_count and o_data.
// The output word is a register loaded with the word that will be at the
// head after each edge, so there is no combinational i_data-to-o_data path.
module cy_skid_fifo #(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter bit OPT_LOWPOWER = 1'b0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_flush,
    cy_skid_fifo_if.slave        bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0]   count_reg, count_next;
    logic [AW:0]   rptr_reg, rptr_next;
    logic [AW:0]   wptr_reg, wptr_next;
    logic          ready_reg, ready_next;
    logic [DW-1:0] data_reg, data_next;
    logic          push, pop;

    assign bus.o_ready = ready_reg;
    assign bus.o_valid = (count_reg != '0);
    assign bus.o_data  = data_reg;
    assign bus.o_count = count_reg;

    // Next-state: handshake decode, pointer/count update, next head word.
    always_comb begin
        push       = bus.i_valid & ready_reg & ~i_flush;
        pop        = (count_reg != '0) & bus.i_ready & ~i_flush;
        count_next = count_reg;
        rptr_next  = rptr_reg;
        wptr_next  = wptr_reg;
        data_next  = data_reg;

        if (i_flush) begin
            count_next = '0;
            rptr_next  = '0;
            wptr_next  = '0;
        end else begin
            if (push) wptr_next = wptr_reg + 1'b1;
            if (pop)  rptr_next = rptr_reg + 1'b1;
            if (push && !pop)      count_next = count_reg + 1'b1;
            else if (pop && !push) count_next = count_reg - 1'b1;
        end

        // The only case where the new head is the slot being written this
        // edge is a push into a buffer that is (or becomes) empty.
        if (count_next == '0) begin
            if (OPT_LOWPOWER) data_next = '0;
        end else if (push && (wptr_reg[AW-1:0] == rptr_next[AW-1:0])) begin
            data_next = bus.i_data;
        end else begin
            data_next = mem[rptr_next[AW-1:0]];
        end

        ready_next = (count_next < FULL_CNT);
    end

    // Control and output registers; reset clears everything at once.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_reg <= '0;
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            ready_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            count_reg <= count_next;
            rptr_reg  <= rptr_next;
            wptr_reg  <= wptr_next;
            ready_reg <= ready_next;
            data_reg  <= data_next;
        end
    end

    // Storage array is left uncleared on reset so it can map to RAM.
    always_ff @(posedge i_clk) begin
        if (push) mem[wptr_reg[AW-1:0]] <= bus.i_data;
    end
endmodule

// File: doc/cy_skid_fifo.md
CY_SKID_FIFO -- requirements
Module: cy_skid_fifo

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data word width in bits (DW >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning storage entries (power of two, DEPTH >= 2); AW = log2(DEPTH).
REQ-003 The block SHALL have parameter OPT_LOWPOWER, default 0, meaning when 1, o_data is forced to zero whenever o_valid = 0.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port i_flush, input, 1 bit: synchronous discard of all stored words.
REQ-007 The block SHALL have port i_valid, input, 1 bit: upstream word present.
REQ-008 The block SHALL have port i_data, input, DW bits: upstream word.
REQ-009 The block SHALL have port o_ready, output, 1 bit: block can accept a word.
REQ-010 The block SHALL have port o_valid, output, 1 bit: output word present.
REQ-011 The block SHALL have port o_data, output, DW bits: output word.
REQ-012 The block SHALL have port i_ready, input, 1 bit: downstream accepts the output word.
REQ-013 The block SHALL have port o_count, output, AW+1 bits: stored-word count, 0..DEPTH.

Function
REQ-014 Push SHALL occur on an edge where i_valid & o_ready & !i_flush; pop on an edge where o_valid & i_ready & !i_flush.
REQ-015 Storage SHALL be a DEPTH-entry circular buffer with AW+1-bit read/write pointers; pointer low AW bits index the buffer, MSB is the wrap bit, and pointers wrap from DEPTH-1 to 0 without error.
REQ-016 o_count SHALL be registered: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-017 o_ready SHALL be a register equal to (next o_count < DEPTH); it SHALL have no combinational path from i_ready or i_valid.
REQ-018 When full (o_count = DEPTH), o_ready SHALL be 0 even if a pop occurs in that cycle; o_ready returns to 1 on the edge after that pop.
REQ-019 o_valid SHALL equal (o_count != 0); o_data SHALL equal the entry at the read pointer (show-ahead).
REQ-020 Latency SHALL be one cycle: a word pushed at edge k appears on o_data/o_valid after edge k when the buffer was empty; there is no combinational i_data-to-o_data bypass.
REQ-021 While o_valid = 1 and i_ready = 0, o_data and o_valid SHALL hold stable.
REQ-022 Words SHALL leave in push order with no loss or duplication.
REQ-023 With OPT_LOWPOWER = 1, o_data SHALL be all-zero while o_valid = 0; with OPT_LOWPOWER = 0, o_data is don't-care while o_valid = 0.
REQ-024 i_flush = 1 at an edge SHALL reset both pointers and o_count to 0 and set o_ready = 1; a push or pop presented in that cycle is discarded.
REQ-025 A push attempted while o_ready = 0 SHALL be ignored; the buffer contents are unchanged.

Reset
REQ-026 While i_reset_n = 0, outputs SHALL be o_valid = 0, o_ready = 0, o_count = 0, and o_data = 0; pointers SHALL be 0. Assertion takes effect immediately, without a clock edge.
REQ-027 o_ready SHALL become 1 at the first rising i_clk edge after i_reset_n deasserts.
REQ-028 Reset asserted mid-operation SHALL discard all stored words; buffer array contents need not be cleared.

Verification (DW = 8, DEPTH = 4)
REQ-029 Reset: hold i_reset_n = 0 with i_valid = 1 -> o_valid = 0, o_ready = 0, o_count = 0, o_data = 0x00; after release, o_ready = 1 at the first edge.
REQ-030 Stream: i_ready = 1; push 0xB3, 0xE3, 0xB3 on consecutive cycles -> o_data shows B3, E3, B3, each one cycle after its push; o_count stays 1; then 0 after the last pop.
REQ-031 Backpressure: i_ready = 0; push 0xF9, 0xB1, 0x85, 0xEF -> o_count = 4, o_ready = 0, o_data holds 0xF9; the next word 0x11 is not accepted; then i_ready = 1 -> drains F9, B1, 85, EF with o_ready = 1 one cycle after the first pop.
REQ-032 Full with simultaneous attempt: at o_count = 4, i_valid = 1 and i_ready = 1 -> no push, o_count = 3, o_ready = 1 next cycle; the following cycle pushes and pops simultaneously and o_count stays 3.
REQ-033 Wrap and flush: push/pop 10 words (pointers wrap twice) with the order checked; at o_count = 2, assert i_flush with i_valid = 1 -> next cycle o_count = 0, o_valid = 0, and the flushed word is never output.
REQ-034 Async reset mid-operation: at o_count = 3, drop i_reset_n between clock edges -> outputs zero immediately; after release, the first pushed word 0xA5 appears as the next output.
